// File: rtl/cpu_pkg.sv
// Shared definitions for the 64-bit CPU datapath. This package holds the
// fetch/decode widths, the IF/ID entry layout and a pointer-width helper.
package cpu_pkg;

    localparam int PC_W    = 64;
    localparam int INSTR_W = 32;

    // One fetched instruction as it travels from fetch to decode.
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } if_id_entry_t;

    // Returns the number of address bits needed to index 'value' entries.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/skid_ram.sv
// Storage array for the IF/ID skid buffer. It has one registered write port
// and one combinational read port, so the head entry is visible in the same
// cycle that its address is presented.
module skid_ram
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 96,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the incoming entry into its slot on the clock edge.
    // NOTE: the array has no reset. Stale contents cannot leak out because the
    // top gates the outputs with out_valid, and the reset leaves count at 0.
    always_ff @(posedge clk) begin
        if (we) begin
            // NOTE: use a non-blocking assignment for every clocked state update
            // so that all flops sample their inputs before any of them change.
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_skid_buffer.sv
// Fetch-to-decode pipeline buffer. It holds up to DEPTH {pc, instr} entries so
// fetch can keep running while decode stalls. It supports a flush that empties
// the buffer and keeps a saturating count of the entries each flush discards.
module if_id_skid_buffer #(
    parameter  int PC_W    = cpu_pkg::PC_W,
    parameter  int INSTR_W = cpu_pkg::INSTR_W,
    parameter  int DEPTH   = 2,
    parameter  int DROP_W  = 8,
    localparam int PTR_W   = cpu_pkg::clog2(DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    input  logic               flush,
    output logic [DROP_W-1:0]  drop_count,
    output logic [CNT_W-1:0]   count
);

    localparam int ENTRY_W = PC_W + INSTR_W;
    localparam int SUM_W   = DROP_W + CNT_W + 1;
    localparam logic [SUM_W-1:0] DROP_MAX = SUM_W'({DROP_W{1'b1}});

    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] rd_data;
    logic [SUM_W-1:0]   drop_sum;
    logic [DROP_W-1:0]  drop_next;

    // in_ready is derived only from the registered occupancy, so there is no
    // combinational path from out_ready back to in_ready.
    assign in_ready  = (count < CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    skid_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .AW    (PTR_W)
    ) u_skid_ram (
        .clk   (clk),
        .we    (push && !flush),
        .waddr (wr_ptr),
        .wdata ({in_pc, in_instr}),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // An empty buffer presents zeros so decode never sees a stale entry.
    assign out_pc    = out_valid ? rd_data[ENTRY_W-1:INSTR_W] : '0;
    assign out_instr = out_valid ? rd_data[INSTR_W-1:0]       : '0;

    // Drop-counter update for a flush: add held entries plus any push that the
    // flush throws away, and clamp at the all-ones value.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can
        // leave it unassigned and infer a latch.
        drop_sum  = '0;
        drop_next = drop_count;
        drop_sum  = SUM_W'(drop_count) + SUM_W'(count) + SUM_W'(push);
        if (drop_sum > DROP_MAX) begin
            drop_next = '1;
        end else begin
            drop_next = drop_sum[DROP_W-1:0];
        end
    end

    // Pointer, occupancy and drop-counter state. Reset beats flush, and flush
    // beats any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            drop_count <= '0;
        end else if (flush) begin
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            drop_count <= drop_next;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_skid_buffer.sv
// Directed bench for the IF/ID skid buffer (DEPTH=2): reset, single transfer,
// fill to full, streaming push+pop, flush with drop-count saturation, reset
// mid-operation, and a random valid/ready run against a queue model.
module tb_if_id_skid_buffer;
    import cpu_pkg::*;

    localparam int DEPTH  = 2;
    localparam int DROP_W = 8;
    localparam int CNT_W  = 2;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [PC_W-1:0]     in_pc;
    logic [INSTR_W-1:0]  in_instr;
    logic                out_valid;
    logic                out_ready;
    logic [PC_W-1:0]     out_pc;
    logic [INSTR_W-1:0]  out_instr;
    logic                flush;
    logic [DROP_W-1:0]   drop_count;
    logic [CNT_W-1:0]    count;

    int checks;
    int errors;

    if_id_entry_t sb[$];

    if_id_skid_buffer #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH),
        .DROP_W  (DROP_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pc      (in_pc),
        .in_instr   (in_instr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_instr  (out_instr),
        .flush      (flush),
        .drop_count (drop_count),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, clock it, and return 1 ns after the edge.
    task automatic step(input logic rn, input logic v, input logic [63:0] pc,
                        input logic [31:0] ins, input logic rdy, input logic fl);
        rst_n     = rn;
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0]  sext;
        if_id_entry_t e;
        logic         v;
        logic         r;
        logic         exp_ready;

        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        out_ready = 1'b0;
        flush     = 1'b0;

        // Reset state.
        step(1'b0, 1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
        check("rst_in_ready",   64'(in_ready),   64'd1);
        check("rst_out_valid",  64'(out_valid),  64'd0);
        check("rst_count",      64'(count),      64'd0);
        check("rst_drop",       64'(drop_count), 64'd0);
        check("rst_out_pc",     out_pc,          64'h0);

        // Single transfer, visible one cycle after the push.
        step(1'b1, 1'b1, 64'h1000, 32'hFFFF_8000, 1'b0, 1'b0);
        check("single_valid", 64'(out_valid), 64'd1);
        check("single_pc",    out_pc,         64'h1000);
        check("single_instr", 64'(out_instr), 64'hFFFF_8000);
        sext = {{32{out_instr[31]}}, out_instr};
        check("single_sext",  sext,           64'hFFFF_FFFF_FFFF_8000);
        step(1'b1, 1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
        check("single_drained", 64'(out_valid), 64'd0);
        check("single_gated",   out_pc,         64'h0);

        // Fill to full with decode stalled.
        step(1'b1, 1'b1, 64'h0, 32'h0000_0013, 1'b0, 1'b0);
        step(1'b1, 1'b1, 64'h4, 32'h0000_0093, 1'b0, 1'b0);
        check("full_count", 64'(count),    64'd2);
        check("full_ready", 64'(in_ready), 64'd0);
        step(1'b1, 1'b1, 64'h8, 32'h0000_0113, 1'b0, 1'b0);
        check("full_reject_count", 64'(count), 64'd2);
        check("full_head_pc",      out_pc,     64'h0);
        check("full_head_instr",   64'(out_instr), 64'h13);
        step(1'b1, 1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
        check("pop1_ready", 64'(in_ready), 64'd1);
        check("pop1_count", 64'(count),    64'd1);
        check("pop1_pc",    out_pc,        64'h4);
        step(1'b1, 1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
        check("pop2_count", 64'(count), 64'd0);

        // Streaming push+pop at count=1: output lags input by one cycle.
        step(1'b1, 1'b1, 64'h0, 32'h0, 1'b0, 1'b0);
        for (int i = 1; i < 8; i++) begin
            check("stream_head_pc", out_pc, 64'(4 * (i - 1)));
            step(1'b1, 1'b1, 64'(4 * i), 32'(i), 1'b1, 1'b0);
            check("stream_count", 64'(count),     64'd1);
            check("stream_instr", 64'(out_instr), 64'(i));
        end
        check("stream_last_pc", out_pc, 64'h1C);
        step(1'b1, 1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
        check("stream_drained", 64'(count), 64'd0);

        // Flush while full: the concurrent in_valid is refused (full), the
        // concurrent pop does not count, so 2 entries are dropped.
        step(1'b1, 1'b1, 64'h100, 32'h1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 64'h104, 32'h2, 1'b0, 1'b0);
        step(1'b1, 1'b1, 64'h108, 32'h3, 1'b1, 1'b1);
        check("flush_count", 64'(count),      64'd0);
        check("flush_valid", 64'(out_valid),  64'd0);
        check("flush_drop",  64'(drop_count), 64'd2);
        check("flush_ready", 64'(in_ready),   64'd1);
        // Flush with count=1 and an accepted push: 1 held + 1 pushed dropped.
        step(1'b1, 1'b1, 64'h200, 32'h4, 1'b0, 1'b0);
        step(1'b1, 1'b1, 64'h204, 32'h5, 1'b0, 1'b1);
        check("flush_push_drop",  64'(drop_count), 64'd4);
        step(1'b1, 1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
        check("flush_push_gone",  64'(out_valid),  64'd0);
        // Step by 2 up to 254, then overflow to the saturated value.
        for (int i = 0; i < 125; i++) begin
            step(1'b1, 1'b1, 64'h300, 32'h6, 1'b0, 1'b0);
            step(1'b1, 1'b1, 64'h304, 32'h7, 1'b0, 1'b0);
            step(1'b1, 1'b0, 64'h0,   32'h0, 1'b0, 1'b1);
        end
        check("drop_254", 64'(drop_count), 64'd254);
        step(1'b1, 1'b1, 64'h400, 32'h8, 1'b0, 1'b0);
        step(1'b1, 1'b1, 64'h404, 32'h9, 1'b0, 1'b0);
        step(1'b1, 1'b0, 64'h0,   32'h0, 1'b0, 1'b1);
        check("drop_sat", 64'(drop_count), 64'd255);
        step(1'b1, 1'b1, 64'h500, 32'hA, 1'b0, 1'b0);
        step(1'b1, 1'b0, 64'h0,   32'h0, 1'b0, 1'b1);
        check("drop_hold", 64'(drop_count), 64'd255);

        // Reset mid-operation with count=2 and drop_count=5.
        step(1'b0, 1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
        check("rst2_drop", 64'(drop_count), 64'd0);
        step(1'b1, 1'b1, 64'h10, 32'h1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 64'h14, 32'h2, 1'b0, 1'b0);
        step(1'b1, 1'b0, 64'h0,  32'h0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 64'h18, 32'h3, 1'b0, 1'b0);
        step(1'b1, 1'b1, 64'h1C, 32'h4, 1'b0, 1'b0);
        step(1'b1, 1'b0, 64'h0,  32'h0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 64'h20, 32'h5, 1'b0, 1'b0);
        step(1'b1, 1'b0, 64'h0,  32'h0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 64'hA0, 32'hAA, 1'b0, 1'b0);
        step(1'b1, 1'b1, 64'hA4, 32'hBB, 1'b0, 1'b0);
        check("pre_rst_count", 64'(count),      64'd2);
        check("pre_rst_drop",  64'(drop_count), 64'd5);
        check("pre_rst_pc",    out_pc,          64'hA0);
        step(1'b0, 1'b1, 64'hA8, 32'hCC, 1'b1, 1'b1);
        check("mid_rst_count", 64'(count),      64'd0);
        check("mid_rst_drop",  64'(drop_count), 64'd0);
        check("mid_rst_ready", 64'(in_ready),   64'd1);
        check("mid_rst_pc",    out_pc,          64'h0);
        check("mid_rst_instr", 64'(out_instr),  64'h0);
        check("mid_rst_valid", 64'(out_valid),  64'd0);

        // Random valid/ready traffic against an in-order queue model.
        sb.delete();
        for (int i = 0; i < 3000; i++) begin
            check("stress_valid", 64'(out_valid), 64'(sb.size() != 0));
            check("stress_count", 64'(count),     64'(sb.size()));
            if (sb.size() != 0) begin
                check("stress_pc",    out_pc,         sb[0].pc);
                check("stress_instr", 64'(out_instr), 64'(sb[0].instr));
            end
            exp_ready = (sb.size() < DEPTH);
            check("stress_in_ready", 64'(in_ready), 64'(exp_ready));
            v       = 1'($urandom_range(0, 1));
            r       = 1'($urandom_range(0, 1));
            e.pc    = {$urandom, $urandom};
            e.instr = $urandom;
            if (r && sb.size() != 0) begin
                void'(sb.pop_front());
            end
            if (v && exp_ready) begin
                sb.push_back(e);
            end
            step(1'b1, v, e.pc, e.instr, r, 1'b0);
        end
        check("stress_drop", 64'(drop_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
